// File: rtl/cache_refill_controller_pkg.sv
// Shared types and constants for the cache miss refill path.
package cache_refill_controller_pkg;

    localparam int OperandSize    = 32;
    localparam int CacheLineWords = 4;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } refill_state_t;

    // Clears the byte and word offset bits of an address within a cache line.
    function automatic logic [OperandSize-1:0] line_base(input logic [OperandSize-1:0] addr);
        line_base = addr & ~(OperandSize'(CacheLineWords * 4 - 1));
    endfunction

endpackage

// File: rtl/cache_refill_controller_mem_word_port.sv
// Main-memory word port: holds req/we/base, walks the beat counter and flags
// the acknowledgement of the last beat of a line.
module cache_refill_controller_mem_word_port
    import cache_refill_controller_pkg::*;
#(
    parameter int LineWords = CacheLineWords,
    parameter int AddrWidth = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_we,
    input  logic [AddrWidth-1:0]         i_base,
    input  logic                         i_ack,
    output logic                         o_req,
    output logic                         o_we,
    output logic [AddrWidth-1:0]         o_addr,
    output logic [$clog2(LineWords)-1:0] o_cnt,
    output logic                         o_beat,
    output logic                         o_last_ack
);

    localparam int CntW = $clog2(LineWords);

    logic                 r_req;
    logic                 r_we;
    logic [AddrWidth-1:0] r_base;
    logic [CntW-1:0]      r_cnt;
    logic                 w_beat;
    logic                 w_last;

    // An ack only counts while a request is outstanding.
    assign w_beat     = r_req & i_ack;
    assign w_last     = (r_cnt == CntW'(LineWords - 1));
    assign o_beat     = w_beat;
    assign o_last_ack = w_beat & w_last;
    assign o_req      = r_req;
    assign o_we       = r_req & r_we;
    assign o_cnt      = r_cnt;
    assign o_addr     = r_req ? (r_base + AddrWidth'({r_cnt, 2'b00})) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_base <= '0;
            r_cnt  <= '0;
        end else if (i_start) begin
            // A start on the last write-back ack chains straight into the fill
            // with req held high.
            r_req  <= 1'b1;
            r_we   <= i_we;
            r_base <= i_base;
            r_cnt  <= '0;
        end else if (w_beat) begin
            if (w_last) begin
                r_req <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CntW'(1);
            end
        end
    end

endmodule

// File: rtl/cache_refill_controller.sv
// Miss sequencer: writes back a dirty victim line, then refills the missing
// line from main memory into the cache fill port.
module cache_refill_controller
    import cache_refill_controller_pkg::*;
#(
    parameter int LineWords = CacheLineWords,
    parameter int AddrWidth = 32,
    parameter int DataWidth = OperandSize
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         miss_req,
    input  logic [AddrWidth-1:0]         miss_addr,
    input  logic                         victim_dirty,
    input  logic [AddrWidth-1:0]         victim_base,
    input  logic [DataWidth-1:0]         victim_rdata,
    output logic [$clog2(LineWords)-1:0] victim_word_idx,
    output logic                         fill_we,
    output logic [$clog2(LineWords)-1:0] fill_word_idx,
    output logic [DataWidth-1:0]         fill_wdata,
    output logic                         miss_done,
    output logic                         busy,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [AddrWidth-1:0]         mem_addr,
    output logic [DataWidth-1:0]         mem_wdata,
    input  logic                         mem_ack,
    input  logic [DataWidth-1:0]         mem_rdata
);

    localparam int                   CntW    = $clog2(LineWords);
    localparam logic [AddrWidth-1:0] OffMask = AddrWidth'(LineWords * 4 - 1);

    refill_state_t        r_state;
    logic [AddrWidth-1:0] r_fill_base;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_start_we;
    logic [AddrWidth-1:0] w_start_base;
    logic [AddrWidth-1:0] w_miss_line;
    logic [AddrWidth-1:0] w_victim_line;
    logic                 w_req;
    logic                 w_we;
    logic [AddrWidth-1:0] w_addr;
    logic [CntW-1:0]      w_cnt;
    logic                 w_beat;
    logic                 w_last_ack;

    assign w_miss_line   = miss_addr & ~OffMask;
    assign w_victim_line = victim_base & ~OffMask;
    assign w_accept      = (r_state == IDLE) && miss_req;

    // The port is (re)started on acceptance and again when write-back ends.
    assign w_start      = w_accept || ((r_state == WB) && w_last_ack);
    assign w_start_we   = (r_state == IDLE) ? victim_dirty : 1'b0;
    assign w_start_base = (r_state != IDLE) ? r_fill_base :
                          (victim_dirty ? w_victim_line : w_miss_line);

    cache_refill_controller_mem_word_port #(
        .LineWords (LineWords),
        .AddrWidth (AddrWidth)
    ) u_port (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_we       (w_start_we),
        .i_base     (w_start_base),
        .i_ack      (mem_ack),
        .o_req      (w_req),
        .o_we       (w_we),
        .o_addr     (w_addr),
        .o_cnt      (w_cnt),
        .o_beat     (w_beat),
        .o_last_ack (w_last_ack)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_fill_base <= '0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (miss_req) begin
                        r_fill_base <= w_miss_line;
                        r_state     <= victim_dirty ? WB : FILL;
                    end
                end
                WB: begin
                    if (w_last_ack) r_state <= FILL;
                end
                FILL: begin
                    if (w_last_ack) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy            = (r_state != IDLE);
    assign miss_done       = r_done;
    assign mem_req         = w_req;
    assign mem_we          = w_we;
    assign mem_addr        = w_addr;
    assign mem_wdata       = ((r_state == WB) && w_req) ? victim_rdata : '0;
    assign victim_word_idx = (r_state == WB) ? w_cnt : '0;
    assign fill_word_idx   = (r_state == FILL) ? w_cnt : '0;
    assign fill_we         = (r_state == FILL) && w_beat;
    assign fill_wdata      = fill_we ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for the cache refill controller with a delayed-ack memory model.
module tb_cache_refill_controller;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_req;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_base;
    logic [31:0] victim_rdata;
    logic [1:0]  victim_word_idx;
    logic        fill_we;
    logic [1:0]  fill_word_idx;
    logic [31:0] fill_wdata;
    logic        miss_done;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Cache array stand-in: victim word content is a fixed function of its index.
    assign victim_rdata = 32'hA5A5_0000 | 32'(victim_word_idx);

    cache_refill_controller dut (
        .clk             (clk),
        .rst             (rst),
        .miss_req        (miss_req),
        .miss_addr       (miss_addr),
        .victim_dirty    (victim_dirty),
        .victim_base     (victim_base),
        .victim_rdata    (victim_rdata),
        .victim_word_idx (victim_word_idx),
        .fill_we         (fill_we),
        .fill_word_idx   (fill_word_idx),
        .fill_wdata      (fill_wdata),
        .miss_done       (miss_done),
        .busy            (busy),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic        dirty;
        logic [31:0] vbase;
        int          delay;
        logic [31:0] exp_fill;
        logic [31:0] exp_wb;
        int          exp_done;
        bit          b2b;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one miss from the acceptance cycle (cycle 0) until the cycle after miss_done.
    task automatic run_miss(input vec_t v);
        int beat;
        int waitc;
        int done_cyc;
        int total;
        int fb;
        bit exp_wr;
        logic [31:0] exp_addr;
        beat     = 0;
        waitc    = 0;
        done_cyc = -1;
        total    = v.dirty ? 2 * N : N;
        miss_req     = 1'b1;
        miss_addr    = v.addr;
        victim_dirty = v.dirty;
        victim_base  = v.vbase;
        for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
            mem_ack = 1'b0;
            chk("req_window", {31'b0, mem_req}, {31'b0, (cyc >= 1 && cyc < v.exp_done)});
            chk("busy", {31'b0, busy}, {31'b0, (cyc >= 1 && cyc <= v.exp_done)});
            if (mem_req && beat < total) begin
                exp_wr   = v.dirty && (beat < N);
                fb       = v.dirty ? beat - N : beat;
                exp_addr = exp_wr ? v.exp_wb + 32'(4 * beat) : v.exp_fill + 32'(4 * fb);
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_we", {31'b0, mem_we}, {31'b0, exp_wr});
                if (exp_wr) chk("mem_wdata", mem_wdata, 32'hA5A5_0000 | 32'(beat));
                if (waitc == v.delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 32'hC0DE_0000 + 32'(beat);
                    #1;
                    chk("fill_we", {31'b0, fill_we}, {31'b0, !exp_wr});
                    if (!exp_wr) begin
                        chk("fill_idx", {30'b0, fill_word_idx}, 32'(fb));
                        chk("fill_wdata", fill_wdata, 32'hC0DE_0000 + 32'(beat));
                    end
                    beat++;
                    waitc = 0;
                end else begin
                    waitc++;
                    #1;
                    chk("fill_we_wait", {31'b0, fill_we}, 32'h0);
                end
            end
            if (miss_done) begin
                done_cyc = cyc;
                chk("beats_at_done", 32'(beat), 32'(total));
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk("done_cycle", 32'(done_cyc), 32'(v.exp_done));
    endtask

    initial begin
        rst          = 1'b0;
        miss_req     = 1'b0;
        miss_addr    = 32'h0;
        victim_dirty = 1'b0;
        victim_base  = 32'h0;
        mem_ack      = 1'b1;
        mem_rdata    = 32'hDEAD_BEEF;

        vecs[0] = '{32'h0000_1234, 1'b0, 32'h0000_9990, 0, 32'h0000_1230, 32'h0, 5, 1'b0};
        vecs[1] = '{32'h0000_4444, 1'b1, 32'h0000_8000, 2, 32'h0000_4440, 32'h0000_8000, 25, 1'b0};
        vecs[2] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 0, 32'hFFFF_FFF0, 32'h0, 5, 1'b0};
        vecs[3] = '{32'h0000_ABCD, 1'b1, 32'hFFFF_FFF0, 1, 32'h0000_ABC0, 32'hFFFF_FFF0, 17, 1'b1};
        vecs[4] = '{32'h1234_5678, 1'b0, 32'h0000_0000, 1, 32'h1234_5670, 32'h0, 9, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_miss_done", {31'b0, miss_done}, 32'h0);
        chk("rst_fill_we", {31'b0, fill_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_fill_wdata", fill_wdata, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);

        rst = 1'b1;
        @(negedge clk);
        // Spurious acks while idle must be ignored.
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            #1;
            chk("spur_fill_we", {31'b0, fill_we}, 32'h0);
            chk("spur_busy", {31'b0, busy}, 32'h0);
            chk("spur_mem_req", {31'b0, mem_req}, 32'h0);
            @(negedge clk);
        end
        mem_ack = 1'b0;

        for (int i = 0; i < 5; i++) begin
            run_miss(vecs[i]);
            if (!vecs[i].b2b) begin
                miss_req = 1'b0;
                repeat (2) begin
                    chk("idle_busy", {31'b0, busy}, 32'h0);
                    @(negedge clk);
                end
            end
        end

        // Reset in the middle of a fill after two beats.
        miss_req     = 1'b1;
        miss_addr    = 32'h0000_2000;
        victim_dirty = 1'b0;
        victim_base  = 32'h0;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'h5555_0000 + 32'(b);
            #1;
            chk("mid_fill_we", {31'b0, fill_we}, 32'h1);
            @(negedge clk);
        end
        chk("mid_addr", mem_addr, 32'h0000_2008);
        #1;
        chk("mid_fill_we_pre", {31'b0, fill_we}, 32'h1);
        rst = 1'b0;
        #1;
        chk("arst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("arst_fill_we", {31'b0, fill_we}, 32'h0);
        chk("arst_busy", {31'b0, busy}, 32'h0);
        chk("arst_mem_addr", mem_addr, 32'h0);
        miss_req = 1'b0;
        mem_ack  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("post_rst_done", {31'b0, miss_done}, 32'h0);
            chk("post_rst_busy", {31'b0, busy}, 32'h0);
            chk("post_rst_req", {31'b0, mem_req}, 32'h0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
